// File: rtl/sdp_dmaunpack_p_pkg.sv
// Shared SDP definitions for the DMA unpacker: sizing helper, slot record
// and the don't-care value driven by unreachable mux arms.
`ifndef X_OR_0
`define X_OR_0 '0
`endif

package sdp_dmaunpack_p_pkg;

  localparam int SDP_IW = 256;
  localparam int SDP_OW = 64;

  // Smallest n with 2**n >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int SDP_CW = clog2(SDP_IW / SDP_OW);

  // One buffered word for the default 256-to-64 configuration.
  typedef struct packed {
    logic [SDP_IW-1:0] data;
    logic [SDP_CW-1:0] nseg;
    logic              eop;
  } sdp_slot_t;

endpackage

// File: rtl/sdp_dmaunpack_p_buf2.sv
// Two-slot FIFO for the DMA unpacker. Full/empty flags are registered so
// the upstream ready never depends combinationally on the downstream pop.
module sdp_dmaunpack_buf2 #(
  parameter int W = 8
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         not_full_o,
  output logic         not_empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         not_full_q, not_empty_q;

  // Callers only push when not full and only pop when not empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    cnt_d    = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      not_full_q  <= 1'b1;
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      not_full_q  <= (cnt_d != 2'd2);
      not_empty_q <= (cnt_d != 2'd0);
    end
  end

  // NOTE: payload storage has no reset; the pointers and flags guard it.
  always_ff @(posedge nvdla_core_clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign not_full_o  = not_full_q;
  assign not_empty_o = not_empty_q;

endmodule

// File: rtl/sdp_dmaunpack_p.sv
// SDP write-path DMA unpacker: splits IW-bit words into OW-bit segments,
// emitting nseg+1 segments per word in ascending order with no bubbles.
module sdp_dmaunpack_p
  import sdp_dmaunpack_p_pkg::*;
#(
  parameter int IW    = 256,
  parameter int OW    = 64,
  localparam int RATIO = IW / OW,
  localparam int CW    = clog2(RATIO)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          inp_pvld,
  output logic          inp_prdy,
  input  logic [IW-1:0] inp_data,
  input  logic [CW-1:0] inp_nseg,
  input  logic          inp_eop,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [OW-1:0] out_data,
  output logic [CW-1:0] out_seg,
  output logic          out_eop
);

  // Same layout as sdp_slot_t, sized by this instance's parameters.
  typedef struct packed {
    logic [IW-1:0] data;
    logic [CW-1:0] nseg;
    logic          eop;
  } slot_t;

  localparam int PW = $bits(slot_t);

  slot_t         wr_slot, head;
  logic          inp_acc, out_acc, is_last, pop, not_full, not_empty;
  logic [CW-1:0] seg_cnt_q, seg_cnt_d;

  assign inp_prdy = not_full;
  assign inp_acc  = inp_pvld & not_full;
  assign wr_slot  = '{data: inp_data, nseg: inp_nseg, eop: inp_eop};

  assign out_pvld = not_empty;
  assign out_acc  = out_pvld & out_prdy;
  assign is_last  = (seg_cnt_q == head.nseg);
  assign pop      = out_acc & is_last;

  sdp_dmaunpack_buf2 #(.W(PW)) u_buf (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .push_i          (inp_acc),
    .wdata_i         (wr_slot),
    .pop_i           (pop),
    .rdata_o         (head),
    .not_full_o      (not_full),
    .not_empty_o     (not_empty)
  );

  always_comb begin
    seg_cnt_d = seg_cnt_q;
    if (out_acc) seg_cnt_d = is_last ? '0 : seg_cnt_q + 1'b1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) seg_cnt_q <= '0;
    else                  seg_cnt_q <= seg_cnt_d;
  end

  // NOTE: the default assignment up front keeps this mux free of latches.
  always_comb begin
    out_data = `X_OR_0;
    for (int k = 0; k < RATIO; k++) begin
      if (seg_cnt_q == CW'(k)) out_data = head.data[k*OW +: OW];
    end
  end

  assign out_seg = seg_cnt_q;
  // Gated by out_pvld so the unreset slot contents never leak onto eop.
  assign out_eop = out_pvld & head.eop & is_last;

`ifndef SYNTHESIS
  a_inp_pvld_known: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !$isunknown(inp_pvld));
  a_out_prdy_known: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !$isunknown(out_prdy));
  a_inp_prdy_known: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !$isunknown(inp_prdy));
  a_inp_pvld_hold: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (inp_pvld && !inp_prdy) |=> inp_pvld);
`endif

endmodule

// File: tb/tb_sdp_dmaunpack_p.sv
// Directed and randomised bench for sdp_dmaunpack_p at 256/64, 512/64 and
// 128/64, with a segment scoreboard for the wider and narrower instances.
module tb_sdp_dmaunpack_p;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: IW=256
  logic         a_inp_pvld, a_inp_prdy, a_inp_eop, a_out_pvld, a_out_prdy, a_out_eop;
  logic [255:0] a_inp_data;
  logic [1:0]   a_inp_nseg, a_out_seg;
  logic [63:0]  a_out_data;
  // Instance B: IW=512
  logic         b_inp_pvld, b_inp_prdy, b_inp_eop, b_out_pvld, b_out_prdy, b_out_eop;
  logic [511:0] b_inp_data;
  logic [2:0]   b_inp_nseg, b_out_seg;
  logic [63:0]  b_out_data;
  // Instance C: IW=128
  logic         c_inp_pvld, c_inp_prdy, c_inp_eop, c_out_pvld, c_out_prdy, c_out_eop;
  logic [127:0] c_inp_data;
  logic [0:0]   c_inp_nseg, c_out_seg;
  logic [63:0]  c_out_data;

  sdp_dmaunpack_p #(.IW(256), .OW(64)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .inp_pvld(a_inp_pvld), .inp_prdy(a_inp_prdy), .inp_data(a_inp_data),
    .inp_nseg(a_inp_nseg), .inp_eop(a_inp_eop),
    .out_pvld(a_out_pvld), .out_prdy(a_out_prdy), .out_data(a_out_data),
    .out_seg(a_out_seg), .out_eop(a_out_eop));

  sdp_dmaunpack_p #(.IW(512), .OW(64)) dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .inp_pvld(b_inp_pvld), .inp_prdy(b_inp_prdy), .inp_data(b_inp_data),
    .inp_nseg(b_inp_nseg), .inp_eop(b_inp_eop),
    .out_pvld(b_out_pvld), .out_prdy(b_out_prdy), .out_data(b_out_data),
    .out_seg(b_out_seg), .out_eop(b_out_eop));

  sdp_dmaunpack_p #(.IW(128), .OW(64)) dut_c (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .inp_pvld(c_inp_pvld), .inp_prdy(c_inp_prdy), .inp_data(c_inp_data),
    .inp_nseg(c_inp_nseg), .inp_eop(c_inp_eop),
    .out_pvld(c_out_pvld), .out_prdy(c_out_prdy), .out_data(c_out_data),
    .out_seg(c_out_seg), .out_eop(c_out_eop));

  typedef struct {
    logic [255:0] data;
    logic [1:0]   nseg;
    logic         eop;
  } word_t;

  typedef struct {
    logic [63:0] data;
    int          seg;
    logic        eop;
  } seg_t;

  word_t stim[$];
  int    ex_w[$], ex_k[$];
  bit    ex_e[$];

  logic        lg_pvld[40], lg_eop[40], lg_iprdy[40], lg_acc[40];
  logic [1:0]  lg_seg[40];
  logic [63:0] lg_data[40];
  bit          prdy_tab[40];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Segment k of word id w: a distinctive 16-bit tag repeated four times.
  function automatic logic [63:0] exp_seg(input int w, input int k);
    logic [15:0] t;
    t = 16'(w * 16 + k);
    return {4{t}};
  endfunction

  function automatic logic [255:0] mk(input int w);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[64*k +: 64] = exp_seg(w, k);
    return r;
  endfunction

  task automatic clear_test();
    stim.delete();
    ex_w.delete();
    ex_k.delete();
    ex_e.delete();
    for (int c = 0; c < 40; c++) prdy_tab[c] = 1'b1;
  endtask

  task automatic add_word(input int w, input int nseg, input bit eop);
    stim.push_back('{mk(w), 2'(nseg), eop});
    for (int k = 0; k <= nseg; k++) begin
      ex_w.push_back(w);
      ex_k.push_back(k);
      ex_e.push_back(eop && (k == nseg));
    end
  endtask

  // Cycle c: sample A's outputs at the negedge, then drive for the next edge.
  task automatic run_a(input int ncyc);
    int wi;
    wi = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      lg_pvld[c]  = a_out_pvld;
      lg_seg[c]   = a_out_seg;
      lg_data[c]  = a_out_data;
      lg_eop[c]   = a_out_eop;
      lg_iprdy[c] = a_inp_prdy;
      a_out_prdy  = prdy_tab[c];
      if (wi < stim.size()) begin
        a_inp_pvld = 1'b1;
        a_inp_data = stim[wi].data;
        a_inp_nseg = stim[wi].nseg;
        a_inp_eop  = stim[wi].eop;
        lg_acc[c]  = a_inp_prdy;
        if (a_inp_prdy) wi++;
      end else begin
        a_inp_pvld = 1'b0;
        lg_acc[c]  = 1'b0;
      end
    end
  endtask

  // Expected segments appear back-to-back from cycle start, then a gap.
  task automatic verify_seq(input string tag, input int start);
    int c;
    for (int i = 0; i < ex_w.size(); i++) begin
      c = start + i;
      check($sformatf("%s_pvld[%0d]", tag, c), lg_pvld[c], 1);
      check($sformatf("%s_seg[%0d]", tag, c), lg_seg[c], ex_k[i]);
      check($sformatf("%s_data[%0d]", tag, c), lg_data[c], exp_seg(ex_w[i], ex_k[i]));
      check($sformatf("%s_eop[%0d]", tag, c), lg_eop[c], ex_e[i]);
    end
    c = start + ex_w.size();
    check($sformatf("%s_idle[%0d]", tag, c), lg_pvld[c], 0);
  endtask

  task automatic sample(input int sel, output logic pv, output logic [63:0] d,
                        output int sg, output logic e, output logic ip);
    if (sel == 1) begin
      pv = b_out_pvld; d = b_out_data; sg = int'(b_out_seg); e = b_out_eop; ip = b_inp_prdy;
    end else begin
      pv = c_out_pvld; d = c_out_data; sg = int'(c_out_seg); e = c_out_eop; ip = c_inp_prdy;
    end
  endtask

  task automatic drive(input int sel, input logic pv, input logic [511:0] d,
                       input logic [2:0] ns, input logic e, input logic op);
    if (sel == 1) begin
      b_inp_pvld = pv; b_inp_data = d; b_inp_nseg = ns; b_inp_eop = e; b_out_prdy = op;
    end else begin
      c_inp_pvld = pv; c_inp_data = d[127:0]; c_inp_nseg = ns[0:0]; c_inp_eop = e; c_out_prdy = op;
    end
  endtask

  task automatic sweep(input int sel, input int nwords, input int ratio);
    seg_t         sb[$];
    seg_t         e;
    logic [511:0] wdata;
    logic [2:0]   wnseg;
    logic         weop, o_pvld, o_eop, i_prdy, oprdy;
    logic [63:0]  o_data;
    int           o_seg, sent, cyc;
    bit           pending;
    sent = 0; cyc = 0; pending = 0;
    wdata = '0; wnseg = '0; weop = 1'b0;
    while ((sent < nwords || pending || sb.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      sample(sel, o_pvld, o_data, o_seg, o_eop, i_prdy);
      oprdy = ($urandom_range(0, 3) != 0);
      if (o_pvld && oprdy) begin
        if (sb.size() == 0) begin
          check($sformatf("sw%0d_unexpected_seg", sel), o_pvld, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("sw%0d_seg", sel), o_seg, e.seg);
          check($sformatf("sw%0d_data", sel), o_data, e.data);
          check($sformatf("sw%0d_eop", sel), o_eop, e.eop);
        end
      end
      if (!pending && sent < nwords && $urandom_range(0, 4) != 0) begin
        for (int j = 0; j < 16; j++) wdata[32*j +: 32] = $urandom();
        wnseg   = 3'($urandom_range(0, ratio - 1));
        weop    = 1'($urandom_range(0, 1));
        pending = 1'b1;
        sent++;
      end
      drive(sel, pending, wdata, wnseg, weop, oprdy);
      if (pending && i_prdy) begin
        for (int k = 0; k <= int'(wnseg); k++)
          sb.push_back('{wdata[64*k +: 64], k, weop && (k == int'(wnseg))});
        pending = 1'b0;
      end
    end
    @(negedge clk);
    drive(sel, 1'b0, wdata, wnseg, 1'b0, 1'b0);
    check($sformatf("sw%0d_in_budget", sel), cyc < 3000, 1);
    check($sformatf("sw%0d_drained", sel), sb.size(), 0);
  endtask

  initial begin
    rstn = 1'b0;
    a_inp_pvld = 0; a_inp_data = '0; a_inp_nseg = '0; a_inp_eop = 0; a_out_prdy = 0;
    b_inp_pvld = 0; b_inp_data = '0; b_inp_nseg = '0; b_inp_eop = 0; b_out_prdy = 0;
    c_inp_pvld = 0; c_inp_data = '0; c_inp_nseg = '0; c_inp_eop = 0; c_out_prdy = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_inp_prdy", a_inp_prdy, 1);
    check("rst_out_pvld", a_out_pvld, 0);
    check("rst_out_seg", a_out_seg, 0);
    check("rst_out_eop", a_out_eop, 0);
    check("rst_b_out_pvld", b_out_pvld, 0);
    check("rst_c_inp_prdy", c_inp_prdy, 1);
    rstn = 1'b1;

    // Four full words streamed with out_prdy high; eop on the third word
    clear_test();
    for (int w = 1; w <= 4; w++) add_word(w, 3, w == 3);
    run_a(20);
    check("t1_idle0", lg_pvld[0], 0);
    verify_seq("t1", 1);

    // Partial word (2 segments) then a full word, no gap between them
    clear_test();
    add_word(5, 1, 1'b1);
    add_word(6, 3, 1'b0);
    run_a(10);
    check("t2_idle0", lg_pvld[0], 0);
    verify_seq("t2", 1);

    // Single-segment words at one word per cycle, input never stalls
    clear_test();
    for (int i = 0; i < 8; i++) add_word(10 + i, 0, (i % 2) == 1);
    run_a(12);
    for (int c = 0; c <= 8; c++) check($sformatf("t3_inp_prdy[%0d]", c), lg_iprdy[c], 1);
    for (int c = 0; c < 8; c++) check($sformatf("t3_acc[%0d]", c), lg_acc[c], 1);
    verify_seq("t3", 1);

    // Backpressure: out_prdy low for cycles 0..7 with three words offered
    clear_test();
    add_word(20, 3, 1'b1);
    add_word(21, 3, 1'b0);
    add_word(22, 3, 1'b0);
    for (int c = 0; c < 8; c++) prdy_tab[c] = 1'b0;
    run_a(26);
    check("t4_acc0", lg_acc[0], 1);
    check("t4_acc1", lg_acc[1], 1);
    for (int c = 2; c <= 11; c++) begin
      check($sformatf("t4_full_prdy[%0d]", c), lg_iprdy[c], 0);
      check($sformatf("t4_full_acc[%0d]", c), lg_acc[c], 0);
    end
    check("t4_refill_prdy12", lg_iprdy[12], 1);
    check("t4_refill_acc12", lg_acc[12], 1);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t4_hold_pvld[%0d]", c), lg_pvld[c], 1);
      check($sformatf("t4_hold_seg[%0d]", c), lg_seg[c], 0);
      check($sformatf("t4_hold_data[%0d]", c), lg_data[c], exp_seg(20, 0));
      check($sformatf("t4_hold_eop[%0d]", c), lg_eop[c], 0);
    end
    verify_seq("t4", 8);

    // Asynchronous reset while the head is on segment 2
    @(negedge clk);
    a_inp_pvld = 1'b1; a_inp_data = mk(30); a_inp_nseg = 2'd3; a_inp_eop = 1'b1;
    a_out_prdy = 1'b1;
    @(negedge clk);
    a_inp_pvld = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_pre_seg", a_out_seg, 2);
    check("t5_pre_data", a_out_data, exp_seg(30, 2));
    #1 rstn = 1'b0;
    #1;
    check("t5_rst_pvld", a_out_pvld, 0);
    check("t5_rst_seg", a_out_seg, 0);
    check("t5_rst_eop", a_out_eop, 0);
    check("t5_rst_inp_prdy", a_inp_prdy, 1);
    @(negedge clk);
    rstn = 1'b1;
    clear_test();
    add_word(31, 3, 1'b0);
    run_a(8);
    check("t5_idle0", lg_pvld[0], 0);
    verify_seq("t5", 1);

    // Randomised sweeps on the 512- and 128-bit instances
    sweep(1, 40, 8);
    sweep(2, 40, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
